decode_imm_sequencer: RTL and testbench

Serializes two-wide fetch bundles into a single-uop-per-cycle decode stream ahead of rename, sharing one immediate generator between both fetch slots. Each accepted bundle is held in a bundle register and decoded one slot per cycle into a registered output stage with a valid/ready handshake. A synchronous flush input supports branch recovery.

---
 rtl/decode_imm_sequencer.sv | 146 ++++++++++++++
 tb/tb_decode_imm_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_imm_sequencer.sv
// Two-wide fetch bundle to single-uop decode stream with a shared immediate generator.
// Output stage is registered behind a valid/ready handshake; flush squashes pending work.
`timescale 1ns/1ps
module decode_imm_sequencer #(
  parameter int unsigned PC_INC = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr0,
  input  logic [31:0] in_instr1,
  input  logic        in_slot1_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic        out_imm_valid,
  output logic        out_slot,
  output logic [7:0]  out_seq
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SEQ_W = 8;

  typedef enum logic [1:0] {ST_EMPTY, ST_S0, ST_S1} state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   b_pc, b_instr0, b_instr1;
  logic              b_slot1_valid;
  logic [SEQ_W-1:0]  seq_cnt;
  logic              advance, accept, load, sel_slot;
  logic [XLEN-1:0]   sel_instr, imm;
  logic              imm_valid;

  assign advance = !out_valid || out_ready;
  assign accept  = in_valid && in_ready;

  // Next-state, slot select and fetch-side ready.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    sel_slot   = 1'b0;
    in_ready   = !flush && (state == ST_EMPTY ||
                 (advance && (state == ST_S1 || (state == ST_S0 && !b_slot1_valid))));
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      if (advance) begin
        case (state)
          ST_S0: begin
            load       = 1'b1;
            state_next = b_slot1_valid ? ST_S1 : ST_EMPTY;
          end
          ST_S1: begin
            load       = 1'b1;
            sel_slot   = 1'b1;
            state_next = ST_EMPTY;
          end
          default: state_next = ST_EMPTY;
        endcase
      end
      // A newly accepted bundle overrides the drain-to-empty transition.
      if (accept) state_next = ST_S0;
    end
  end

  // Shared immediate generator on whichever slot is being emitted.
  always_comb begin
    sel_instr = sel_slot ? b_instr1 : b_instr0;
    imm       = '0;
    imm_valid = 1'b0;
    case (sel_instr[6:0])
      7'b0010011, 7'b1100111, 7'b0000011: begin
        imm       = {{20{sel_instr[31]}}, sel_instr[31:20]};
        imm_valid = 1'b1;
      end
      7'b0110111: begin
        imm       = {sel_instr[31:12], 12'b0};
        imm_valid = 1'b1;
      end
      7'b1100011: begin
        imm       = {{20{sel_instr[31]}}, sel_instr[7], sel_instr[30:25], sel_instr[11:8], 1'b0};
        imm_valid = 1'b1;
      end
      7'b0100011: begin
        imm       = {{20{sel_instr[31]}}, sel_instr[31:25], sel_instr[11:7]};
        imm_valid = 1'b1;
      end
      default: begin
        imm       = '0;
        imm_valid = 1'b0;
      end
    endcase
  end

  // State and bundle register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_EMPTY;
      b_pc          <= '0;
      b_instr0      <= '0;
      b_instr1      <= '0;
      b_slot1_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        b_pc          <= in_pc;
        b_instr0      <= in_instr0;
        b_instr1      <= in_instr1;
        b_slot1_valid <= in_slot1_valid;
      end
    end
  end

  // Output stage; fields other than valid hold across flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      out_instr     <= '0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_imm_valid <= 1'b0;
      out_slot      <= 1'b0;
      out_seq       <= '0;
      seq_cnt       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= load;
      if (load) begin
        out_instr     <= sel_instr;
        out_pc        <= sel_slot ? b_pc + XLEN'(PC_INC) : b_pc;
        out_imm       <= imm;
        out_imm_valid <= imm_valid;
        out_slot      <= sel_slot;
        out_seq       <= seq_cnt;
        seq_cnt       <= seq_cnt + SEQ_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decode_imm_sequencer.sv
// Scoreboarded bench for decode_imm_sequencer: directed scenarios plus randomized traffic.
`timescale 1ns/1ps
module tb_decode_imm_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, in_slot1_valid;
  logic [31:0] in_pc, in_instr0, in_instr1;
  logic        out_valid, out_ready, out_imm_valid, out_slot;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [7:0]  out_seq;

  decode_imm_sequencer #(.PC_INC(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .in_slot1_valid(in_slot1_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm(out_imm), .out_imm_valid(out_imm_valid),
    .out_slot(out_slot), .out_seq(out_seq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic        iv;
    logic        slot;
  } uop_t;

  uop_t       exp_q[$];
  logic [7:0] exp_seq;
  int         checks = 0;
  int         errors = 0;
  int         wraps  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the architectural immediate formats.
  function automatic uop_t model_uop(input logic [31:0] pc, input logic [31:0] instr, input logic slot);
    uop_t u;
    int   v;
    u.pc    = slot ? pc + 32'd4 : pc;
    u.instr = instr;
    u.slot  = slot;
    u.iv    = 1'b1;
    case (instr & 32'h7f)
      32'h13, 32'h67, 32'h03: u.imm = 32'($signed(instr) >>> 20);
      32'h37: u.imm = instr & 32'hFFFFF000;
      32'h63: begin
        v = int'(((instr >> 31) & 1) << 12) + int'(((instr >> 7) & 1) << 11)
          + int'(((instr >> 25) & 63) << 5) + int'(((instr >> 8) & 15) << 1);
        if (v >= 4096) v = v - 8192;
        u.imm = 32'(v);
      end
      32'h23: begin
        v = int'(((instr >> 25) & 127) << 5) + int'((instr >> 7) & 31);
        if (v >= 2048) v = v - 4096;
        u.imm = 32'(v);
      end
      default: begin u.imm = 32'd0; u.iv = 1'b0; end
    endcase
    return u;
  endfunction

  // Monitor: consume expected uops on handshakes, squash on flush, enqueue on accept.
  always @(negedge clk) begin
    uop_t e;
    if (!reset_n) begin
      exp_q.delete();
      exp_seq = 8'd0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_uop actual pc=%0h expected none", out_pc);
        end else begin
          e = exp_q.pop_front();
          check("uop", 160'({out_pc, out_instr, out_imm, out_imm_valid, out_slot, out_seq}),
                       160'({e.pc, e.instr, e.imm, e.iv, e.slot, exp_seq}));
          if (exp_seq == 8'd255) wraps++;
          exp_seq = exp_seq + 8'd1;
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) begin
        exp_q.push_back(model_uop(in_pc, in_instr0, 1'b0));
        if (in_slot1_valid) exp_q.push_back(model_uop(in_pc, in_instr1, 1'b1));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1, input logic v1);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_pc = pc; in_instr0 = i0; in_instr1 = i1; in_slot1_valid = v1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual in_ready=0 expected 1");
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [8];
    ops = '{7'h13, 7'h67, 7'h03, 7'h37, 7'h63, 7'h23, 7'h33, 7'h0f};
    return {$urandom() >> 7, 7'b0} | 32'(ops[$urandom_range(0, 7)]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic        acc;
    logic [31:0] bpc;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_instr0 = '0; in_instr1 = '0; in_slot1_valid = 1'b0;
    #12;
    check("reset_outputs", 160'({out_valid, out_instr, out_pc, out_imm, out_imm_valid, out_slot, out_seq}), 160'(0));
    @(posedge clk); #2 reset_n = 1'b1;
    step();
    check("reset_in_ready", 160'(in_ready), 160'(1));

    // First bundle: latency, values and slot ordering.
    send(32'h100, 32'hFFF00093, 32'h12345137, 1'b1);
    step();
    check("b1_slot0", 160'({out_valid, out_pc, out_imm, out_slot, out_seq}), 160'({1'b1, 32'h100, 32'hFFFFFFFF, 1'b0, 8'd0}));
    step();
    check("b1_slot1", 160'({out_valid, out_pc, out_imm, out_slot, out_seq}), 160'({1'b1, 32'h104, 32'h12345000, 1'b1, 8'd1}));

    // Branch/store immediates, then an unsupported single-slot bundle.
    send(32'h200, 32'hFE209CE3, 32'h0020A223, 1'b1);
    step();
    check("branch_imm", 160'({out_imm, out_imm_valid}), 160'({32'hFFFFFFF8, 1'b1}));
    step();
    check("store_imm", 160'({out_imm, out_imm_valid}), 160'({32'h00000004, 1'b1}));
    send(32'h300, 32'h002081B3, 32'h0, 1'b0);
    step();
    check("rtype_imm", 160'({out_valid, out_imm, out_imm_valid}), 160'({1'b1, 32'h0, 1'b0}));
    step();
    check("single_empty", 160'(out_valid), 160'(0));
    step();

    // Back-to-back two-slot bundles with in_valid held high.
    bpc = 32'h1000;
    in_valid = 1'b1; in_pc = bpc; in_instr0 = rand_instr(); in_instr1 = rand_instr(); in_slot1_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", c), 160'(in_ready), 160'((c % 2) == 0));
      check($sformatf("b2b_valid_%0d", c), 160'(out_valid), 160'(c >= 2));
      acc = in_ready;
      step();
      if (acc) begin
        bpc = bpc + 32'h10;
        in_pc = bpc; in_instr0 = rand_instr(); in_instr1 = rand_instr();
      end
    end
    in_valid = 1'b0;
    repeat (4) step();

    // Backpressure mid-bundle.
    send(32'h2000, 32'h00500113, 32'hABCDE0B7, 1'b1);
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_ready", 160'(in_ready), 160'(0));
      check("stall_hold", 160'({out_valid, out_pc, out_instr, out_slot}), 160'({1'b1, 32'h2000, 32'h00500113, 1'b0}));
      step();
    end
    out_ready = 1'b1;
    step();
    check("stall_slot1", 160'({out_valid, out_pc, out_slot}), 160'({1'b1, 32'h2004, 1'b1}));
    repeat (2) step();

    // Flush while slot 1 is pending, with a competing bundle offered.
    send(32'h3000, 32'h00A00193, 32'h00B00213, 1'b1);
    step();
    flush = 1'b1;
    in_valid = 1'b1; in_pc = 32'h4000; in_instr0 = 32'h00C00293; in_instr1 = 32'h0; in_slot1_valid = 1'b0;
    @(negedge clk);
    check("flush_ready", 160'(in_ready), 160'(0));
    step();
    flush = 1'b0;
    check("flush_valid", 160'(out_valid), 160'(0));
    step();
    in_valid = 1'b0;
    step();
    check("flush_restart", 160'({out_valid, out_pc, out_slot}), 160'({1'b1, 32'h4000, 1'b0}));
    repeat (2) step();

    // Randomized traffic; flush only issued while the consumer is ready.
    for (int c = 0; c < 800; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = out_ready && ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      in_pc     = $urandom() & 32'hFFFFFFFC;
      in_instr0 = rand_instr();
      in_instr1 = rand_instr();
      in_slot1_valid = $urandom_range(0, 3) != 0;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();
    check("queue_drained", 160'(exp_q.size()), 160'(0));
    check("seq_wrapped", 160'(wraps >= 1), 160'(1));

    // Asynchronous reset mid-bundle.
    send(32'h5000, 32'h00100093, 32'h00200113, 1'b1);
    step();
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", 160'({out_valid, out_instr, out_pc, out_imm, out_imm_valid, out_slot, out_seq}), 160'(0));
    step();
    reset_n = 1'b1;
    #1;
    check("post_reset_ready", 160'({in_ready, out_valid}), 160'({1'b1, 1'b0}));
    send(32'h6000, 32'h00300193, 32'h0, 1'b0);
    step();
    check("post_reset_seq", 160'({out_valid, out_pc, out_seq}), 160'({1'b1, 32'h6000, 8'd0}));
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
